// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: NOP encoding, major opcodes and the fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes, shared with the main decoder/controller
    localparam logic [6:0] OPC_R    = 7'b011_0011;
    localparam logic [6:0] OPC_I    = 7'b001_0011;
    localparam logic [6:0] OPC_LW   = 7'b000_0011;
    localparam logic [6:0] OPC_SW   = 7'b010_0011;
    localparam logic [6:0] OPC_BR   = 7'b110_0011;
    localparam logic [6:0] OPC_LUI  = 7'b011_0111;
    localparam logic [6:0] OPC_JAL  = 7'b110_1111;
    localparam logic [6:0] OPC_JALR = 7'b110_0111;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer that parks one fetched instruction and its PC while ID is stalled.
module fetch_hold_buf #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    // Clear (flush) beats load; load and drain never coincide since a full buffer blocks fetches
    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch with one outstanding memory request, load-use stall skid buffer,
// redirect flush with in-flight response kill, and the IF/ID pipeline register.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_id,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc4,
    output logic [INSTR_W-1:0] if_id_instr
);

    localparam logic [INSTR_W-1:0] NOP    = INSTR_W'(NOP_INSTR);
    localparam logic [PC_W-1:0]    PC_INC = PC_W'(4);

    fetch_state_t       state, state_next;
    logic               kill, kill_next;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    req_pc;
    logic               hold_full;
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_pc;
    logic               accept_rsp;
    logic               hold_load;
    logic               hold_drain;

    // A response is useful only when it answers a live (non-killed) request
    assign accept_rsp = (state == S_WAIT) && imem_rvalid && !kill;
    assign hold_load  = accept_rsp && stall_id && !redirect;
    assign hold_drain = hold_full && !stall_id && !redirect;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        kill_next  = kill;
        case (state)
            S_REQ: begin
                if (!redirect && !hold_full) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // In-flight request must be killed unless it returns right now
                    if (imem_rvalid) begin
                        state_next = S_REQ;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    kill_next = 1'b0;
                    if (kill || stall_id) begin
                        state_next = S_REQ;
                    end
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Output logic: fetch_pc always tracks req_pc + 4 once a request is issued
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        if (!reset) begin
            case (state)
                S_REQ:   imem_req = !redirect && !hold_full;
                S_WAIT:  imem_req = imem_rvalid && !kill && !redirect && !stall_id;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // Fetch address bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + PC_INC;
            end
            if (imem_req) begin
                req_pc <= fetch_pc;
            end
        end
    end

    fetch_hold_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .drain      (hold_drain),
        .clear      (redirect),
        .load_instr (imem_rdata),
        .load_pc    (req_pc),
        .full       (hold_full),
        .instr      (hold_instr),
        .pc         (hold_pc)
    );

    // IF/ID register: flush > stall hold > buffered entry > fresh response > bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= NOP;
        end else if (redirect) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP;
        end else if (!stall_id) begin
            if (hold_full) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= hold_pc;
                if_id_pc4   <= hold_pc + PC_INC;
                if_id_instr <= hold_instr;
            end else if (accept_rsp) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc;
                if_id_pc4   <= req_pc + PC_INC;
                if_id_instr <= imem_rdata;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP;
            end
        end
    end

    a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
        imem_req |-> (state == S_REQ || imem_rvalid));

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main decoder/controller.
- Generates the PC and issues one-outstanding-request fetches to instruction memory.
- Buffers the returned instruction and presents it to ID; the decoder takes its 7-bit Opcode from if_id_instr[6:0].
- Handles load-use stalls from the hazard unit and branch/jal/jalr redirects with flush.

Parameters:
- PC_W, 32, width of PC and memory address.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle fetch request pulse; always accepted by memory.
- imem_addr  out  PC_W  fetch address, valid when imem_req=1.
- imem_rvalid  in  1  response valid, at least 1 cycle after its request.
- imem_rdata  in  INSTR_W  fetched instruction, valid with imem_rvalid.
- stall_id  in  1  ID cannot accept; hold IF/ID contents.
- redirect  in  1  taken branch/jal/jalr resolved; flush and refetch.
- redirect_pc  in  PC_W  target address, valid with redirect.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  PC_W  PC of if_id_instr.
- if_id_pc4  out  PC_W  if_id_pc + 4, used for jal/jalr link.
- if_id_instr  out  INSTR_W  instruction to decode; NOP 32'h0000_0013 when invalid.

Behaviour:
- Reset values:
  - if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP.
  - imem_req=0.
  - fetch_pc=RESET_PC, state=S_REQ.
  - Kill flag and hold buffer cleared.
  - Responses arriving during the reset cycle are ignored.
- FSM states: S_REQ, S_WAIT.
  - S_REQ: imem_req=1, imem_addr=fetch_pc. Record req_pc=fetch_pc, go to S_WAIT.
  - S_WAIT on imem_rvalid, kill=0: deliver the response to IF/ID, or to the hold buffer if stalled.
    - If IF/ID can accept next cycle, issue the next request in the same cycle: imem_req=1, addr=req_pc+4 (back-to-back); stay in S_WAIT.
    - Otherwise go to S_REQ once the hold buffer drains.
  - S_WAIT on imem_rvalid, kill=1: drop the response, clear kill, go to S_REQ.
- Throughput: 1-cycle memory yields one instruction per cycle after a 2-cycle startup (first valid IF/ID at cycle 2 after reset release).
- PC arithmetic: +4 modulo 2^PC_W; the wrap from all-ones-minus-3 to 0 is allowed and not flagged.
- Stall (stall_id=1, redirect=0):
  - IF/ID outputs hold.
  - A response arriving during the stall goes into the single-entry hold buffer (instr, pc).
  - No new request is issued while the hold buffer is full.
  - When the stall drops, the hold buffer loads IF/ID the next edge and fetching resumes.
- Redirect (highest priority; overrides stall):
  - Next edge: if_id_valid=0, if_id_instr=NOP, hold buffer cleared, fetch_pc=redirect_pc.
  - If a request is outstanding and not returned this cycle, set kill and stay in S_WAIT; otherwise go to S_REQ.
  - A response arriving in the same cycle as redirect is discarded.
- Redirect repeated while kill=1: update fetch_pc to the newest target. Only one kill is needed because there is only one outstanding request.
- No request is ever issued while a request is outstanding; this invariant is checked by assertion.
- Reset mid-operation (including S_WAIT with kill set) returns everything to reset values on the next edge.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - Opcode constants (R, I, LW, SW, BR, LUI, JAL, JALR), shared with the controller.
  - fetch_state_t enum {S_REQ, S_WAIT}.
- One sub-module, fetch_hold_buf: single-entry instr/pc buffer with load, drain and clear inputs and a full flag.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 at 0x0, 32'h00A00113 at 0x4 -> if_id_pc=0x0 then 0x4 on consecutive cycles, if_id_valid=1, imem_addr sequence 0,4,8.
- stall_id high 3 cycles while a response 32'h002081B3 arrives -> IF/ID frozen, no imem_req while buffer full, buffered instr appears 1 cycle after stall drops, no loss or duplication.
- redirect to 0x40 with request to 0xC outstanding (3-cycle memory) -> 0xC response dropped, next imem_addr=0x40, if_id_valid=0 for the bubble, then pc=0x40.
- redirect and stall_id asserted together -> flush wins: if_id_instr=NOP, fetch resumes at redirect_pc.
- reset asserted in S_WAIT with kill set -> outputs at reset values next edge, next fetch at RESET_PC, stale response ignored.
- RESET_PC=32'hFFFF_FFFC -> second fetch address is 0x0 (wrap-around).
